// File: rtl/datapath_unit.sv
// Datapath executing one control word per cycle: 16x16 register file, 256x16
// synchronous data memory, 8-function ALU and the RF write-source mux.
module datapath_unit #(
  parameter int DATA_W   = 16,
  parameter int RF_DEPTH = 16,
  parameter int DM_DEPTH = 256,
  localparam int RF_AW   = $clog2(RF_DEPTH),
  localparam int DM_AW   = $clog2(DM_DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DM_AW-1:0]  D_Addr,
  input  logic              D_Wr,
  input  logic              RF_s,
  input  logic              RF_W_en,
  input  logic [RF_AW-1:0]  RF_W_Addr,
  input  logic [RF_AW-1:0]  RF_Ra_Addr,
  input  logic [RF_AW-1:0]  RF_Rb_Addr,
  input  logic [2:0]        ALU_s0,
  output logic [DATA_W-1:0] Ra_Data,
  output logic [DATA_W-1:0] Rb_Data,
  output logic [DATA_W-1:0] ALU_Out,
  output logic [DATA_W-1:0] DM_Q,
  output logic [DATA_W-1:0] RF_W_Data
);

  localparam logic [2:0] ALU_ZERO = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_PASS = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_AND  = 3'b110;
  localparam logic [2:0] ALU_INC  = 3'b111;

  logic [DATA_W-1:0] rf [RF_DEPTH];
  logic [DATA_W-1:0] dm [DM_DEPTH];

  // Register file: asynchronous reads, so a same-cycle write is not bypassed.
  assign Ra_Data = rf[RF_Ra_Addr];
  assign Rb_Data = rf[RF_Rb_Addr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; this is what makes Ra=Rb=W ALU ops read old data.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
    end else if (RF_W_en) begin
      rf[RF_W_Addr] <= RF_W_Data;
    end
  end

  // NOTE: the data-memory array has no reset so it maps onto block RAM; only
  // the suppressed write sees Reset, the contents survive it.
  always_ff @(posedge Clk) begin
    if (D_Wr && !Reset) dm[D_Addr] <= Ra_Data;
  end

  // Registered read port returns the pre-write contents on a same-address write.
  always_ff @(posedge Clk) begin
    if (Reset) DM_Q <= '0;
    else       DM_Q <= dm[D_Addr];
  end

  // NOTE: the ALU is always_comb with a default assignment ahead of the case,
  // so no path can leave ALU_Out unassigned and infer a latch.
  always_comb begin
    ALU_Out = '0;
    case (ALU_s0)
      ALU_ZERO: ALU_Out = '0;
      ALU_ADD:  ALU_Out = Ra_Data + Rb_Data;
      ALU_SUB:  ALU_Out = Ra_Data - Rb_Data;
      ALU_PASS: ALU_Out = Ra_Data;
      ALU_XOR:  ALU_Out = Ra_Data ^ Rb_Data;
      ALU_OR:   ALU_Out = Ra_Data | Rb_Data;
      ALU_AND:  ALU_Out = Ra_Data & Rb_Data;
      ALU_INC:  ALU_Out = Ra_Data + DATA_W'(1);
      default:  ALU_Out = '0;
    endcase
  end

  assign RF_W_Data = RF_s ? DM_Q : ALU_Out;

endmodule

// File: tb/tb_datapath_unit.sv
// Self-checking bench for datapath_unit: table-driven ALU vectors plus directed
// sequences for load/store, reset and same-address corner cases.
module tb_datapath_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [7:0]  D_Addr;
  logic        D_Wr;
  logic        RF_s;
  logic        RF_W_en;
  logic [3:0]  RF_W_Addr;
  logic [3:0]  RF_Ra_Addr;
  logic [3:0]  RF_Rb_Addr;
  logic [2:0]  ALU_s0;
  logic [15:0] Ra_Data;
  logic [15:0] Rb_Data;
  logic [15:0] ALU_Out;
  logic [15:0] DM_Q;
  logic [15:0] RF_W_Data;

  int checks = 0;
  int errors = 0;

  datapath_unit dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .D_Addr     (D_Addr),
    .D_Wr       (D_Wr),
    .RF_s       (RF_s),
    .RF_W_en    (RF_W_en),
    .RF_W_Addr  (RF_W_Addr),
    .RF_Ra_Addr (RF_Ra_Addr),
    .RF_Rb_Addr (RF_Rb_Addr),
    .ALU_s0     (ALU_s0),
    .Ra_Data    (Ra_Data),
    .Rb_Data    (Rb_Data),
    .ALU_Out    (ALU_Out),
    .DM_Q       (DM_Q),
    .RF_W_Data  (RF_W_Data)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [2:0]  op;
    logic [15:0] exp;
  } alu_vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    D_Wr = 1'b0; RF_W_en = 1'b0; RF_s = 1'b0; ALU_s0 = 3'b000;
    D_Addr = 8'h00; RF_W_Addr = 4'h0; RF_Ra_Addr = 4'h0; RF_Rb_Addr = 4'h0;
  endtask

  // Builds an arbitrary constant in RF[r] with clear, then double / increment per bit.
  task automatic set_reg(input logic [3:0] r, input logic [15:0] v);
    idle();
    RF_W_Addr = r; RF_W_en = 1'b1; RF_s = 1'b0; ALU_s0 = 3'b000;
    tick();
    RF_Ra_Addr = r; RF_Rb_Addr = r;
    for (int i = 15; i >= 0; i--) begin
      ALU_s0 = 3'b001;
      tick();
      if (v[i]) begin
        ALU_s0 = 3'b111;
        tick();
      end
    end
    idle();
  endtask

  task automatic store(input logic [3:0] r, input logic [7:0] a);
    idle();
    RF_Ra_Addr = r; D_Addr = a; D_Wr = 1'b1;
    tick();
    idle();
  endtask

  task automatic read_reg(input logic [3:0] r, input logic [15:0] exp, input string name);
    RF_Ra_Addr = r;
    #1;
    check(name, Ra_Data, exp);
  endtask

  alu_vec_t vecs [16];

  initial begin
    vecs[0]  = '{4'd6, 4'd7, 3'd0, 16'h0000};
    vecs[1]  = '{4'd6, 4'd7, 3'd1, 16'h0000};
    vecs[2]  = '{4'd6, 4'd7, 3'd2, 16'hFFFE};
    vecs[3]  = '{4'd6, 4'd7, 3'd3, 16'hFFFF};
    vecs[4]  = '{4'd6, 4'd7, 3'd4, 16'hFFFE};
    vecs[5]  = '{4'd6, 4'd7, 3'd5, 16'hFFFF};
    vecs[6]  = '{4'd6, 4'd7, 3'd6, 16'h0001};
    vecs[7]  = '{4'd6, 4'd7, 3'd7, 16'h0000};
    vecs[8]  = '{4'd3, 4'd8, 3'd1, 16'h2143};
    vecs[9]  = '{4'd3, 4'd8, 3'd2, 16'h0325};
    vecs[10] = '{4'd3, 4'd8, 3'd4, 16'h1D3B};
    vecs[11] = '{4'd3, 4'd8, 3'd5, 16'h1F3F};
    vecs[12] = '{4'd3, 4'd8, 3'd6, 16'h0204};
    vecs[13] = '{4'd3, 4'd8, 3'd7, 16'h1235};
    vecs[14] = '{4'd7, 4'd6, 3'd2, 16'h0002};
    vecs[15] = '{4'd8, 4'd3, 3'd3, 16'h0F0F};

    idle();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("init_dm_q", DM_Q, 16'h0000);
    check("init_rf_w_data", RF_W_Data, 16'h0000);
    check("init_alu_out", ALU_Out, 16'h0000);

    // Reset clears a preloaded RF and a non-zero DM_Q.
    set_reg(4'd1, 16'h1111);
    set_reg(4'd15, 16'hF00D);
    store(4'd15, 8'h01);
    D_Addr = 8'h01;
    tick();
    check("pre_reset_dm_q", DM_Q, 16'hF00D);
    read_reg(4'd1, 16'h1111, "pre_reset_rf1");
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    idle();
    check("reset_dm_q", DM_Q, 16'h0000);
    for (int i = 0; i < 16; i++) begin
      RF_Ra_Addr = 4'(i); RF_Rb_Addr = 4'(15 - i);
      #1;
      check($sformatf("reset_ra_%0d", i), Ra_Data, 16'h0000);
      check($sformatf("reset_rb_%0d", 15 - i), Rb_Data, 16'h0000);
    end

    // Store / load round trip via DM[80h].
    set_reg(4'd3, 16'h1234);
    store(4'd3, 8'h80);
    D_Addr = 8'h80; RF_s = 1'b1;
    tick();
    check("load_dm_q", DM_Q, 16'h1234);
    check("load_rf_w_data", RF_W_Data, 16'h1234);
    RF_W_en = 1'b1; RF_W_Addr = 4'd5;
    tick();
    idle();
    read_reg(4'd5, 16'h1234, "load_rf5");

    // ALU vector table.
    set_reg(4'd6, 16'hFFFF);
    set_reg(4'd7, 16'h0001);
    set_reg(4'd8, 16'h0F0F);
    for (int i = 0; i < 16; i++) begin
      RF_Ra_Addr = vecs[i].ra; RF_Rb_Addr = vecs[i].rb; ALU_s0 = vecs[i].op; RF_s = 1'b0;
      #1;
      check($sformatf("alu_vec_%0d", i), ALU_Out, vecs[i].exp);
      check($sformatf("alu_wdata_%0d", i), RF_W_Data, vecs[i].exp);
    end
    idle();

    // Read-during-write on DM[10h] returns the old word.
    set_reg(4'd9, 16'hAAAA);
    store(4'd9, 8'h10);
    set_reg(4'd10, 16'h5555);
    RF_Ra_Addr = 4'd10; D_Addr = 8'h10; D_Wr = 1'b1;
    tick();
    check("rdw_old", DM_Q, 16'hAAAA);
    D_Wr = 1'b0;
    tick();
    check("rdw_new", DM_Q, 16'h5555);

    // Ra = W = 2 increment: pre-edge operand, result visible after the edge.
    set_reg(4'd2, 16'h0007);
    RF_Ra_Addr = 4'd2; RF_Rb_Addr = 4'd2; RF_W_Addr = 4'd2; ALU_s0 = 3'd7;
    RF_s = 1'b0; RF_W_en = 1'b1;
    #1;
    check("same_addr_alu1", ALU_Out, 16'h0008);
    check("same_addr_old", Ra_Data, 16'h0007);
    tick();
    check("same_addr_rf1", Ra_Data, 16'h0008);
    check("same_addr_alu2", ALU_Out, 16'h0009);
    tick();
    idle();
    read_reg(4'd2, 16'h0009, "same_addr_rf2");

    // Simultaneous D_Wr and load-write: RF gets the pre-write DM_Q.
    D_Addr = 8'h10;
    tick();
    RF_Ra_Addr = 4'd3; D_Wr = 1'b1; RF_W_en = 1'b1; RF_s = 1'b1; RF_W_Addr = 4'd11;
    tick();
    check("simul_dm_q_old", DM_Q, 16'h5555);
    idle();
    read_reg(4'd11, 16'h5555, "simul_rf11");
    D_Addr = 8'h10;
    tick();
    check("simul_dm_new", DM_Q, 16'h1234);

    // Reset beats RF_W_en and D_Wr in the same cycle.
    set_reg(4'd12, 16'hBEEF);
    set_reg(4'd13, 16'hC0DE);
    store(4'd13, 8'h20);
    Reset = 1'b1; RF_Ra_Addr = 4'd12; ALU_s0 = 3'd3; RF_s = 1'b0;
    RF_W_en = 1'b1; RF_W_Addr = 4'd4; D_Wr = 1'b1; D_Addr = 8'h20;
    #1;
    check("rst_prio_alu", ALU_Out, 16'hBEEF);
    tick();
    Reset = 1'b0;
    idle();
    check("rst_prio_dm_q", DM_Q, 16'h0000);
    read_reg(4'd4, 16'h0000, "rst_prio_rf4");
    read_reg(4'd12, 16'h0000, "rst_prio_rf12");
    D_Addr = 8'h20;
    tick();
    check("rst_prio_dm20", DM_Q, 16'hC0DE);

    // Reset between load cycles discards the pending load.
    D_Addr = 8'h80; RF_s = 1'b1;
    tick();
    check("mid_load_dm_q", DM_Q, 16'h1234);
    Reset = 1'b1; RF_W_en = 1'b1; RF_W_Addr = 4'd14;
    tick();
    Reset = 1'b0;
    idle();
    check("mid_load_dm_q_rst", DM_Q, 16'h0000);
    read_reg(4'd14, 16'h0000, "mid_load_rf14");
    read_reg(4'd5, 16'h0000, "mid_load_rf5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
